// File: rtl/demux_tdm_pkg.sv
// Shared types and constants for the 1-to-4, 4-bit time-division demultiplexer.
// Build option: DEMUX_PARITY_EN (see demux1to4_4bit_tdm).
package demux_tdm_pkg;

  localparam int DATA_W  = 4;
  localparam int N_SLOTS = 4;
  localparam int SLOT_W  = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Plain-constant view of the state encoding, for code that keeps state in a logic vector.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);

  // Odd number of ones in {par, data} means an even-parity violation.
  function automatic logic parity_bad(input logic par, input logic [DATA_W-1:0] data);
    return ^{par, data};
  endfunction

endpackage

// File: rtl/dec2to4.sv
// Combinational 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module dec2to4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    if (en) begin
      y[a] = 1'b1;
    end
  end

endmodule

// File: rtl/demux1to4_4bit_tdm.sv
// Receive-side TDM demux: stages slots 0..2, publishes all four lanes when slot 3 arrives.
// Build option: define DEMUX_PARITY_EN to add din_par/par_err even-parity checking.
//
// Handshake: valid qualifies din and sync on the same cycle; there is no ready, every
// valid sample is consumed on the clock edge it is presented. sync without valid is ignored.
module demux1to4_4bit_tdm
  import demux_tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              valid,
  input  logic              sync,
`ifdef DEMUX_PARITY_EN
  input  logic              din_par,
  output logic              par_err,
`endif
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3,
  output logic [SLOT_W-1:0] sel,
  output logic              frame_done,
  output logic              sync_err,
  output logic [0:0]        state_dbg
);

  logic [0:0]        state;
  logic [DATA_W-1:0] stage0;
  logic [DATA_W-1:0] stage1;
  logic [DATA_W-1:0] stage2;
  logic              start;
  logic              mid_en;
  logic [3:0]        slot_we;
  logic              unused_slot_we0;

  assign start  = valid && sync;
  assign mid_en = valid && !sync && (state == ST_RUN);

  dec2to4 u_dec (
    .en (mid_en),
    .a  (sel),
    .y  (slot_we)
  );

  // sel never reads 0 while in RUN; slot 0 is always written through the sync path.
  assign unused_slot_we0 = slot_we[0];
  assign state_dbg       = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= '0;
      stage0     <= '0;
      stage1     <= '0;
      stage2     <= '0;
      q0         <= '0;
      q1         <= '0;
      q2         <= '0;
      q3         <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (start) begin
        // A sync in RUN abandons the partial frame; published lanes are left alone.
        stage0 <= din;
        sel    <= SLOT_W'(1);
        state  <= ST_RUN;
        if (state == ST_RUN) begin
          sync_err <= 1'b1;
        end
      end else begin
        if (slot_we[1]) begin
          stage1 <= din;
          sel    <= sel + SLOT_W'(1);
        end
        if (slot_we[2]) begin
          stage2 <= din;
          sel    <= sel + SLOT_W'(1);
        end
        if (slot_we[3]) begin
          q0         <= stage0;
          q1         <= stage1;
          q2         <= stage2;
          q3         <= din;
          frame_done <= 1'b1;
          sel        <= '0;
          state      <= ST_IDLE;
        end
      end
    end
  end

`ifdef DEMUX_PARITY_EN
  logic par_acc;
  logic sample_bad;

  assign sample_bad = parity_bad(din_par, din);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc <= 1'b0;
      par_err <= 1'b0;
    end else if (start) begin
      par_acc <= sample_bad;
    end else if (mid_en) begin
      par_acc <= par_acc | sample_bad;
      if (slot_we[3]) begin
        par_err <= par_acc | sample_bad;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux1to4_4bit_tdm.sv
// Directed bench for demux1to4_4bit_tdm; parity steps are added when DEMUX_PARITY_EN is defined.
module tb_demux1to4_4bit_tdm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din = '0;
  logic       valid = 1'b0;
  logic       sync = 1'b0;
  logic       din_par = 1'b0;
  logic [3:0] q0, q1, q2, q3;
  logic [1:0] sel;
  logic       frame_done, sync_err;
  logic [0:0] state_dbg;
`ifdef DEMUX_PARITY_EN
  logic       par_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux1to4_4bit_tdm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .valid      (valid),
    .sync       (sync),
`ifdef DEMUX_PARITY_EN
    .din_par    (din_par),
    .par_err    (par_err),
`endif
    .q0         (q0),
    .q1         (q1),
    .q2         (q2),
    .q3         (q3),
    .sel        (sel),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .state_dbg  (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [15:0] exp);
    chk(tag, {q0, q1, q2, q3}, {16'h0, exp});
  endtask

  // One valid sample; outputs are sampled 1 time unit after the accepting edge.
  task automatic send_p(input logic [3:0] d, input logic s, input logic bad_par);
    @(negedge clk);
    din     = d;
    valid   = 1'b1;
    sync    = s;
    din_par = (^d) ^ bad_par;
    @(posedge clk);
    #1;
    valid = 1'b0;
    sync  = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input logic s);
    send_p(d, s, 1'b0);
  endtask

  // Idle cycles with valid low; sync is deliberately held high to show it is ignored.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b0;
      sync  = 1'b1;
      din   = 4'hE;
      @(posedge clk);
      #1;
      sync = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_q("rst_q", 16'h0000);
    chk("rst_sel", sel, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_se", sync_err, 0);
    chk("rst_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame A,B,C,D
    send(4'hA, 1'b1); chk("f1_sel0", sel, 1); chk("f1_fd0", frame_done, 0);
    send(4'hB, 1'b0); chk("f1_sel1", sel, 2);
    send(4'hC, 1'b0); chk("f1_sel2", sel, 3); chk_q("f1_q_hold", 16'h0000);
    send(4'hD, 1'b0); chk("f1_sel3", sel, 0); chk("f1_fd", frame_done, 1);
    chk_q("f1_q", 16'hABCD); chk("f1_state", state_dbg, 0);
    gap(1); chk("f1_fd_pulse", frame_done, 0); chk_q("f1_q_keep", 16'hABCD);

    // Gaps of 0..3 cycles between samples
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    gap(1); chk("gap_sel2", sel, 2);
    send(4'h3, 1'b0);
    gap(3); chk("gap_sel3", sel, 3); chk("gap_fd0", frame_done, 0);
    chk("gap_se0", sync_err, 0); chk_q("gap_q_hold", 16'hABCD);
    send(4'h4, 1'b0); chk("gap_fd", frame_done, 1); chk_q("gap_q", 16'h1234);

    // Resync mid-frame
    send(4'h5, 1'b1);
    send(4'h6, 1'b0);
    send(4'h7, 1'b1); chk("rs_se", sync_err, 1); chk("rs_sel", sel, 1);
    chk("rs_fd0", frame_done, 0); chk_q("rs_q_hold", 16'h1234);
    send(4'h8, 1'b0); chk("rs_se_pulse", sync_err, 0);
    send(4'h9, 1'b0);
    send(4'hA, 1'b0); chk("rs_fd", frame_done, 1); chk_q("rs_q", 16'h789A);

    // Unsynced samples in IDLE are dropped
    send(4'hF, 1'b0); send(4'hF, 1'b0); send(4'hF, 1'b0);
    chk("idle_sel", sel, 0); chk("idle_se", sync_err, 0); chk("idle_state", state_dbg, 0);
    chk_q("idle_q_hold", 16'h789A);
    send(4'hB, 1'b1); send(4'hC, 1'b0); send(4'hD, 1'b0); send(4'hE, 1'b0);
    chk("idle_fd", frame_done, 1); chk_q("idle_q", 16'hBCDE);

    // Asynchronous reset mid-frame
    send(4'h1, 1'b1); send(4'h2, 1'b0); send(4'h3, 1'b0);
    chk("mr_sel3", sel, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_q("mr_q", 16'h0000); chk("mr_sel", sel, 0); chk("mr_state", state_dbg, 0);
    chk("mr_fd", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(1); chk("mr_fd_none", frame_done, 0);
    send(4'h4, 1'b1); chk("mr_fd_s0", frame_done, 0);
    send(4'h5, 1'b0); chk("mr_fd_s1", frame_done, 0);
    send(4'h6, 1'b0); chk("mr_fd_s2", frame_done, 0);
    send(4'h7, 1'b0); chk("mr_fd_s3", frame_done, 1); chk_q("mr_q_new", 16'h4567);
    gap(1); chk("mr_fd_once", frame_done, 0);

    // Back-to-back frames with no bubble
    send(4'h8, 1'b1); send(4'h9, 1'b0); send(4'hA, 1'b0); send(4'hB, 1'b0);
    chk("b2b_fd1", frame_done, 1); chk_q("b2b_q1", 16'h89AB);
    send(4'hC, 1'b1); chk("b2b_fd_drop", frame_done, 0); chk("b2b_se", sync_err, 0);
    chk("b2b_sel", sel, 1);
    send(4'hD, 1'b0); send(4'hE, 1'b0); send(4'hF, 1'b0);
    chk("b2b_fd2", frame_done, 1); chk_q("b2b_q2", 16'hCDEF);

`ifdef DEMUX_PARITY_EN
    chk("par_clean0", par_err, 0);
    send_p(4'h1, 1'b1, 1'b0); send_p(4'h2, 1'b0, 1'b0);
    send_p(4'h3, 1'b0, 1'b1); send_p(4'h4, 1'b0, 1'b0);
    chk("par_bad_fd", frame_done, 1); chk("par_bad", par_err, 1);
    chk_q("par_bad_q", 16'h1234);
    gap(2); chk("par_hold", par_err, 1);
    send_p(4'h5, 1'b1, 1'b0); send_p(4'h6, 1'b0, 1'b0);
    send_p(4'h7, 1'b0, 1'b0); send_p(4'h8, 1'b0, 1'b0);
    chk("par_clean_fd", frame_done, 1); chk("par_clean", par_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
